// File: rtl/sd_gate_pkg.sv
// rtl/sd_gate_pkg.sv - shared state encoding and default constants for the SD gate sequencer
package sd_gate_pkg;

  // Sequencer states, kept as plain 2-bit constants for legacy tools
  typedef logic [1:0] sd_state_t;

  localparam sd_state_t ST_IDLE  = 2'd0;
  localparam sd_state_t ST_ARMED = 2'd1;
  localparam sd_state_t ST_COUNT = 2'd2;
  localparam sd_state_t ST_DONE  = 2'd3;

  // Default gate timing: close after 146 edges, resend restarts at 80, 1 ms idle abort at 50 MHz
  localparam int DEF_EDGE_W         = 8;
  localparam int DEF_CLOSE_EDGE     = 146;
  localparam int DEF_RESEND_LOAD    = 80;
  localparam int DEF_TMO_W          = 16;
  localparam int DEF_TIMEOUT_CYCLES = 50000;

  // The sequencer is busy while waiting for or counting SD clock edges
  function automatic logic state_is_busy(input sd_state_t s);
    return (s == ST_ARMED) || (s == ST_COUNT);
  endfunction

endpackage

// File: rtl/sd_sync_edge.sv
// rtl/sd_sync_edge.sv - two-flop synchroniser with one-cycle rise and fall pulses
module sd_sync_edge
  import sd_gate_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Resolve metastability over two flops, then keep the previous settled value for edge detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/sd_gate_sequencer.sv
// rtl/sd_gate_sequencer.sv - counts SD clock edges and closes the card-line gate at a programmed count
module sd_gate_sequencer
  import sd_gate_pkg::*;
#(
  parameter int EDGE_W         = DEF_EDGE_W,
  parameter int CLOSE_EDGE     = DEF_CLOSE_EDGE,
  parameter int RESEND_LOAD    = DEF_RESEND_LOAD,
  parameter int TMO_W          = DEF_TMO_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              sd_clk_in,
  input  logic              start_btn,
  input  logic              resend_btn,
  output logic              gate_signal,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [EDGE_W-1:0] edge_count
);

  localparam logic [EDGE_W-1:0] CLOSE_V  = EDGE_W'(CLOSE_EDGE);
  localparam logic [EDGE_W-1:0] RESEND_V = EDGE_W'(RESEND_LOAD);
  localparam logic [EDGE_W-1:0] ONE_V    = EDGE_W'(1);
  localparam logic [TMO_W-1:0]  TMO_V    = TMO_W'(TIMEOUT_CYCLES);

  logic sd_rise;
  logic start_p;
  logic resend_p;
  logic unused_edges;
  logic sd_fall;
  logic start_rise;
  logic resend_rise;

  sd_state_t         state_q, state_n;
  logic [EDGE_W-1:0] edge_q, edge_n, edge_inc;
  logic [TMO_W-1:0]  timer_q, timer_n, timer_inc;
  logic              timer_hit;
  logic              gate_q, gate_n;
  logic              done_q, done_n;
  logic              tmo_q, tmo_n;
  logic              busy_q;

  // SD clock idles low; buttons are active-low and idle high, so their synchronisers reset high
  sd_sync_edge #(.RESET_VAL(1'b0)) u_sync_sd (
    .clk      (CLOCK_50),
    .reset_n  (reset_n),
    .async_in (sd_clk_in),
    .rise     (sd_rise),
    .fall     (sd_fall)
  );

  sd_sync_edge #(.RESET_VAL(1'b1)) u_sync_start (
    .clk      (CLOCK_50),
    .reset_n  (reset_n),
    .async_in (start_btn),
    .rise     (start_rise),
    .fall     (start_p)
  );

  sd_sync_edge #(.RESET_VAL(1'b1)) u_sync_resend (
    .clk      (CLOCK_50),
    .reset_n  (reset_n),
    .async_in (resend_btn),
    .rise     (resend_rise),
    .fall     (resend_p)
  );

  assign unused_edges = sd_fall | start_rise | resend_rise;

  assign edge_inc  = edge_q + ONE_V;
  assign timer_inc = (timer_q == TMO_V) ? timer_q : timer_q + TMO_W'(1);
  assign timer_hit = (timer_inc == TMO_V);

  // Next-state decode; start beats resend, resend beats a rise, and a rise beats the idle timeout
  always_comb begin
    state_n = state_q;
    edge_n  = edge_q;
    timer_n = timer_q;
    gate_n  = gate_q;
    done_n  = 1'b0;
    tmo_n   = tmo_q;

    if (start_p) begin
      state_n = ST_ARMED;
      edge_n  = '0;
      timer_n = '0;
      tmo_n   = 1'b0;
      gate_n  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          timer_n = '0;
        end

        ST_ARMED: begin
          if (sd_rise) begin
            state_n = ST_COUNT;
            edge_n  = ONE_V;
            timer_n = '0;
          end else if (timer_hit) begin
            state_n = ST_IDLE;
            tmo_n   = 1'b1;
            timer_n = '0;
          end else begin
            timer_n = timer_inc;
          end
        end

        ST_COUNT: begin
          if (resend_p) begin
            edge_n  = RESEND_V;
            timer_n = '0;
            gate_n  = 1'b1;
          end else if (sd_rise) begin
            edge_n  = edge_inc;
            timer_n = '0;
            if (edge_inc == CLOSE_V) begin
              gate_n  = 1'b0;
              done_n  = 1'b1;
              state_n = ST_DONE;
            end
          end else if (timer_hit) begin
            state_n = ST_IDLE;
            tmo_n   = 1'b1;
            gate_n  = 1'b1;
            timer_n = '0;
          end else begin
            timer_n = timer_inc;
          end
        end

        ST_DONE: begin
          gate_n  = 1'b0;
          timer_n = '0;
          if (resend_p) begin
            state_n = ST_COUNT;
            edge_n  = RESEND_V;
            gate_n  = 1'b1;
          end
        end

        default: begin
          state_n = ST_IDLE;
          gate_n  = 1'b1;
          timer_n = '0;
        end
      endcase
    end
  end

  // Register state, counters and flags; busy is decoded from the next state so it lines up with it
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      edge_q  <= '0;
      timer_q <= '0;
      gate_q  <= 1'b1;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      edge_q  <= edge_n;
      timer_q <= timer_n;
      gate_q  <= gate_n;
      done_q  <= done_n;
      tmo_q   <= tmo_n;
      busy_q  <= state_is_busy(state_n);
    end
  end

  assign gate_signal = gate_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = tmo_q;
  assign edge_count  = edge_q;

endmodule
